axi_rd_arbiter: RTL and testbench
=================================

// Module: axi_rd_arbiter
// PURPOSE
//  Two-master round-robin arbiter sharing the single AXI4 read channel to memory between icache (m0) and dcache (m1).
//  Grants one master per burst, forwards AR and R handshakes to the owner, and never preempts a burst before rlast.
//  Sits between the cache refill ports and the memory interface; both caches see standard AXI4 read slaves.
// PARAMETERS
//  ADDR_W   32       address width
//  DATA_W   64       read data width
//  ARSIZE   3'd3     s_arsize driven on every request (8 B/beat)
// PORTS
//  clk         in   1          clock
//  rst         in   1          reset, asynchronous, active-low
//  m_araddr    in   2*ADDR_W   per-master read address; [ADDR_W-1:0]=m0
//  m_arvalid   in   2          per-master address valid
//  m_arlen     in   2*8        per-master burst length (beats-1)
//  m_arready   out  2          per-master address accepted
//  m_rdata     out  DATA_W     read data, broadcast to both masters
//  m_rresp     out  2          read response, broadcast
//  m_rvalid    out  2          per-master read valid (owner only)
//  m_rlast     out  2          per-master last beat (owner only)
//  m_rready    in   2          per-master read ready
//  s_araddr    out  ADDR_W     downstream address
//  s_arvalid   out  1          downstream address valid
//  s_arlen     out  8          downstream burst length
//  s_arsize    out  3          = ARSIZE
//  s_arburst   out  2          = 2'b01 (INCR)
//  s_arready   in   1          downstream address ready
//  s_rdata     in   DATA_W     downstream read data
//  s_rresp     in   2          downstream read response
//  s_rvalid    in   1          downstream read valid
//  s_rlast     in   1          downstream last beat
//  s_rready    out  1          downstream read ready
//  owner       out  1          current/last granted master
//  beat_err    out  1          sticky: rlast beat count != arlen+1
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, owner=1 (m0 wins first tie), beat_cnt=0, beat_err=0; s_arvalid, s_rready, m_arready, m_rvalid, m_rlast = 0.
//  - States IDLE -> ADDR -> DATA -> IDLE. No other transitions.
//  - IDLE: if any m_arvalid: grant g; one requester -> it; both -> !owner (round-robin). Latch araddr/arlen of g, owner<=g, -> ADDR. Request-to-s_arvalid latency 1 cycle.
//  - ADDR: s_arvalid=1 with latched addr/len; m_arready[g]=s_arready (combinational), other m_arready=0. On s_arvalid&s_arready -> DATA, beat_cnt<=0.
//  - DATA: s_rready=m_rready[g]; m_rvalid[g]=s_rvalid, m_rlast[g]=s_rlast; non-owner rvalid/rlast=0. Each s_rvalid&s_rready: beat_cnt++ (8-bit).
//  - Handshake with s_rlast -> IDLE. If beat_cnt != latched arlen on that beat -> beat_err<=1 (sticky until reset). Owner keeps bus until rlast; no timeout.
//  - Requests arriving in ADDR/DATA see m_arready=0 and stay pending; minimum 1 idle cycle between bursts.
//  - Latched address used in ADDR: master dropping arvalid early does not alter the issued request.
//  - s_rvalid outside DATA: ignored, s_rready=0.
//  - Reset mid-burst: immediate return to IDLE, s_arvalid/s_rready drop asynchronously; downstream shares the reset.
// STRUCTURE
//  - Package axi_rd_pkg: state enum {IDLE,ADDR,DATA}, AXI_BURST_INCR=2'b01, AXI_SIZE_8B=3'd3, AXI_RESP_OKAY=2'b00.
//  - Sub-module rr_arb2: 2-way round-robin pick (req[1:0], last -> gnt index, valid); purely combinational.
//  - Top holds FSM, request latch, beat counter, mux/demux of R channel.
// TESTING
//  - m0 alone: araddr=0x8000_0040, arlen=7, s_arready after 2 cyc, 8 beats -> s_araddr=0x8000_0040, m_rvalid[0] x8, m_rlast[0] on beat 8, m_rvalid[1]=0 always.
//  - Both request same cycle after reset -> m0 served first, m1 next with 1 idle cycle between; third tie -> m0 again.
//  - m1 arrives during m0 DATA with m_rready[0] toggling 1/0 -> s_rready mirrors m_rready[0], m1 arready held 0 until m0 rlast.
//  - Slave asserts rlast on beat 4 of arlen=7 -> beat_err=1, FSM to IDLE; stays 1 through next clean burst.
//  - rst low during beat 3 of a burst -> same edge all outputs 0, state IDLE; new m1 request after release completes with s_arlen from m1.

Source files
------------

// File: rtl/axi_rd_pkg.sv
// Shared types and AXI encodings for the two-master read arbiter.
//   state_e        : burst FSM states (IDLE -> ADDR -> DATA -> IDLE)
//   AXI_BURST_INCR : burst type driven on every downstream request
//   AXI_SIZE_8B    : default beat size (8 bytes per beat)
//   AXI_RESP_OKAY  : normal read response encoding
package axi_rd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick, purely combinational.
//   i_req   [1:0] : request vector, bit 0 = m0, bit 1 = m1
//   i_last        : index of the master granted most recently
//   o_gnt         : index of the master to grant
//   o_valid       : at least one request present
// On a tie the master that was NOT granted last wins.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_gnt,
    output logic       o_valid
);

    // Grant selection: single requester wins outright, tie alternates.
    always_comb begin
        o_gnt   = 1'b0;
        o_valid = |i_req;
        case (i_req)
            2'b01:   o_gnt = 1'b0;
            2'b10:   o_gnt = 1'b1;
            2'b11:   o_gnt = ~i_last;
            default: o_gnt = 1'b0;
        endcase
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel between icache (m0)
// and dcache (m1). One master owns the channel for a whole burst; the
// burst is never preempted before rlast.
//   clk, rst         : clock, asynchronous active-low reset
//   m_araddr/arlen   : per-master AR payload, low slice = m0
//   m_arvalid/arready: per-master AR handshake (arready only to owner)
//   m_rdata/rresp    : R payload broadcast to both masters
//   m_rvalid/rlast   : R qualifiers, owner only
//   m_rready         : per-master R ready
//   s_*              : downstream AXI4 read master interface
//   owner            : current / most recently granted master
//   beat_err         : sticky, set when rlast arrives on a beat count
//                      different from arlen+1
module axi_rd_arbiter
    import axi_rd_pkg::*;
#(
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 64,
    parameter logic [2:0] ARSIZE = AXI_SIZE_8B
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2*ADDR_W-1:0] m_araddr,
    input  logic [1:0]          m_arvalid,
    input  logic [15:0]         m_arlen,
    output logic [1:0]          m_arready,
    output logic [DATA_W-1:0]   m_rdata,
    output logic [1:0]          m_rresp,
    output logic [1:0]          m_rvalid,
    output logic [1:0]          m_rlast,
    input  logic [1:0]          m_rready,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic                s_arvalid,
    output logic [7:0]          s_arlen,
    output logic [2:0]          s_arsize,
    output logic [1:0]          s_arburst,
    input  logic                s_arready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rvalid,
    input  logic                s_rlast,
    output logic                s_rready,
    output logic                owner,
    output logic                beat_err
);

    state_e            r_state;
    state_e            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic              r_owner;
    logic [7:0]        r_beat_cnt;
    logic              r_beat_err;
    logic              w_gnt;
    logic              w_gnt_vld;
    logic              w_ar_hs;
    logic              w_r_hs;

    rr_arb2 u_arb (
        .i_req   (m_arvalid),
        .i_last  (r_owner),
        .o_gnt   (w_gnt),
        .o_valid (w_gnt_vld)
    );

    assign w_ar_hs   = (r_state == ADDR) && s_arready;
    assign w_r_hs    = (r_state == DATA) && s_rvalid && m_rready[r_owner];

    // The request is issued from the latch, so a master withdrawing
    // arvalid early cannot change what goes downstream.
    assign s_araddr  = r_addr;
    assign s_arlen   = r_len;
    assign s_arsize  = ARSIZE;
    assign s_arburst = AXI_BURST_INCR;
    assign m_rdata   = s_rdata;
    assign m_rresp   = s_rresp;
    assign owner     = r_owner;
    assign beat_err  = r_beat_err;

    // FSM state register; reset forces IDLE so handshakes drop at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and channel steering: only the owner sees AR/R qualifiers.
    always_comb begin
        w_next    = r_state;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        m_arready = 2'b00;
        m_rvalid  = 2'b00;
        m_rlast   = 2'b00;
        case (r_state)
            IDLE: begin
                if (w_gnt_vld) begin
                    w_next = ADDR;
                end else begin
                    w_next = IDLE;
                end
            end
            ADDR: begin
                s_arvalid          = 1'b1;
                m_arready[r_owner] = s_arready;
                if (s_arready) begin
                    w_next = DATA;
                end else begin
                    w_next = ADDR;
                end
            end
            DATA: begin
                s_rready          = m_rready[r_owner];
                m_rvalid[r_owner] = s_rvalid;
                m_rlast[r_owner]  = s_rlast;
                if (w_r_hs && s_rlast) begin
                    w_next = IDLE;
                end else begin
                    w_next = DATA;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Request latch, beat counter and sticky length-mismatch flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr     <= '0;
            r_len      <= 8'd0;
            r_owner    <= 1'b1;
            r_beat_cnt <= 8'd0;
            r_beat_err <= 1'b0;
        end else begin
            if ((r_state == IDLE) && w_gnt_vld) begin
                r_owner <= w_gnt;
                r_addr  <= w_gnt ? m_araddr[2*ADDR_W-1:ADDR_W] : m_araddr[ADDR_W-1:0];
                r_len   <= w_gnt ? m_arlen[15:8] : m_arlen[7:0];
            end
            if (w_ar_hs) begin
                r_beat_cnt <= 8'd0;
            end else if (w_r_hs) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
            end
            // Counter holds beats already accepted, so on the last beat it
            // must equal arlen.
            if (w_r_hs && s_rlast && (r_beat_cnt != r_len)) begin
                r_beat_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter. A slave-side task serves one
// burst cycle by cycle and records what it observes; each test pushes its
// expected AR requests and read beats to queues and compares after serving.
module tb_axi_rd_arbiter;
    import axi_rd_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] m_araddr;
    logic [1:0]  m_arvalid;
    logic [15:0] m_arlen;
    logic [1:0]  m_arready;
    logic [63:0] m_rdata;
    logic [1:0]  m_rresp;
    logic [1:0]  m_rvalid;
    logic [1:0]  m_rlast;
    logic [1:0]  m_rready;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst;
    logic        s_arready;
    logic [63:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rlast;
    logic        s_rready;
    logic        owner;
    logic        beat_err;

    axi_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arlen(m_arlen),
        .m_arready(m_arready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid),
        .s_rlast(s_rlast), .s_rready(s_rready), .owner(owner), .beat_err(beat_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        own;
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    ar_t         exp_ar_q[$];
    ar_t         obs_ar_q[$];
    logic [63:0] exp_r_q[$];
    logic [63:0] obs_r_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Observations from the most recent serve call.
    int         cnt_rv0, cnt_rv1, rlast_beat, rr_mis, other_rv, other_ar, ar_wait, tmo;
    logic [9:0] rst_snap;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst       = 1'b0;
        m_araddr  = 64'd0;
        m_arvalid = 2'b00;
        m_arlen   = 16'd0;
        m_rready  = 2'b11;
        s_arready = 1'b0;
        s_rdata   = 64'd0;
        s_rresp   = AXI_RESP_OKAY;
        s_rvalid  = 1'b0;
        s_rlast   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Slave model for one burst: waits for s_arvalid, accepts after ar_dly
    // cycles, then returns nbeats beats (rlast on the last one) with data
    // {dseed, beat}. Optionally raises m1 during DATA or pulls reset when
    // beat index rst_at is presented.
    task automatic serve(input int ar_dly, input int nbeats, input bit toggle,
                         input bit late_m1, input int rst_at, input logic [31:0] dseed);
        int   n;
        int   beat;
        logic own;
        bit   ph;
        bit   aborted;
        cnt_rv0 = 0; cnt_rv1 = 0; rlast_beat = -1; rr_mis = 0;
        other_rv = 0; other_ar = 0; aborted = 1'b0;
        n = 0;
        while (s_arvalid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        ar_wait = n;
        if (s_arvalid !== 1'b1) begin
            tmo++;
            return;
        end
        own = owner;
        repeat (ar_dly) begin
            if (m_arready !== 2'b00) other_ar++;
            step();
        end
        s_arready = 1'b1;
        #1;
        if (m_arready[own] !== 1'b1 || m_arready[~own] !== 1'b0) other_ar++;
        obs_ar_q.push_back({own, s_araddr, s_arlen});
        step();
        s_arready      = 1'b0;
        m_arvalid[own] = 1'b0;
        if (late_m1) m_arvalid[1] = 1'b1;
        beat = 0;
        n    = 0;
        ph   = 1'b1;
        while (beat < nbeats && n < 200) begin
            m_rready[own] = toggle ? ph : 1'b1;
            ph       = ~ph;
            s_rvalid = 1'b1;
            s_rdata  = {dseed, 32'(beat)};
            s_rlast  = (beat == nbeats - 1);
            if (beat == rst_at) begin
                rst = 1'b0;
                #1;
                rst_snap = {s_arvalid, s_rready, m_arready, m_rvalid, m_rlast, owner, beat_err};
                aborted  = 1'b1;
                break;
            end
            #1;
            if (s_rready !== m_rready[own]) rr_mis++;
            if (m_rvalid[~own] !== 1'b0 || m_rlast[~own] !== 1'b0) other_rv++;
            if (m_arready !== 2'b00) other_ar++;
            if (m_rvalid[own] === 1'b1 && s_rready === 1'b1) begin
                if (own) cnt_rv1++; else cnt_rv0++;
                obs_r_q.push_back(m_rdata);
                if (m_rlast[own] === 1'b1) rlast_beat = beat + 1;
                beat++;
            end
            step();
            n++;
        end
        if (!aborted && beat < nbeats) tmo++;
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        m_rready = 2'b11;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_checks++;
        if ({s_arvalid, s_rready} !== 2'b00) begin
            n_fail++; $display("FAIL reset_s_valid_ready got=%b exp=00", {s_arvalid, s_rready});
        end
        n_checks++;
        if ({m_arready, m_rvalid, m_rlast} !== 6'b000000) begin
            n_fail++; $display("FAIL reset_m_qual got=%b exp=000000", {m_arready, m_rvalid, m_rlast});
        end
        n_checks++;
        if (owner !== 1'b1) begin
            n_fail++; $display("FAIL reset_owner got=%b exp=1", owner);
        end
        n_checks++;
        if (beat_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_beat_err got=%b exp=0", beat_err);
        end
        n_checks++;
        if ({s_arsize, s_arburst} !== {3'd3, 2'b01}) begin
            n_fail++; $display("FAIL reset_size_burst got=%b exp=01101", {s_arsize, s_arburst});
        end
        n_checks++;
        if (dut.r_state !== IDLE) begin
            n_fail++; $display("FAIL reset_state got=%0d exp=0", dut.r_state);
        end
    endtask

    task automatic test_m0_single();
        ar_t         got, exp;
        logic [63:0] ev, ov;
        step();
        m_araddr[31:0] = 32'h8000_0040;
        m_arlen[7:0]   = 8'd7;
        m_arvalid      = 2'b01;
        exp_ar_q.push_back({1'b0, 32'h8000_0040, 8'd7});
        for (int b = 0; b < 8; b++) exp_r_q.push_back({32'hC0DE_0001, 32'(b)});
        serve(2, 8, 1'b0, 1'b0, -1, 32'hC0DE_0001);
        n_checks++;
        if (ar_wait !== 1) begin
            n_fail++; $display("FAIL m0_ar_latency got=%0d exp=1", ar_wait);
        end
        n_checks++;
        exp = exp_ar_q.pop_front();
        if (obs_ar_q.size() == 0) got = 'x; else got = obs_ar_q.pop_front();
        if (got !== exp) begin
            n_fail++; $display("FAIL m0_ar got=%h exp=%h", got, exp);
        end
        n_checks++;
        if ({cnt_rv0, cnt_rv1} !== {32'd8, 32'd0}) begin
            n_fail++; $display("FAIL m0_beats got=%0d/%0d exp=8/0", cnt_rv0, cnt_rv1);
        end
        n_checks++;
        if (rlast_beat !== 8) begin
            n_fail++; $display("FAIL m0_rlast_beat got=%0d exp=8", rlast_beat);
        end
        n_checks++;
        if ({other_rv, other_ar, rr_mis, tmo} !== 128'd0) begin
            n_fail++; $display("FAIL m0_isolation got=%0d/%0d/%0d/%0d exp=0/0/0/0", other_rv, other_ar, rr_mis, tmo);
        end
        while (exp_r_q.size() > 0) begin
            ev = exp_r_q.pop_front();
            if (obs_r_q.size() == 0) ov = 'x; else ov = obs_r_q.pop_front();
            n_checks++;
            if (ov !== ev) begin
                n_fail++; $display("FAIL m0_rdata got=%h exp=%h", ov, ev);
            end
        end
        n_checks++;
        if (beat_err !== 1'b0) begin
            n_fail++; $display("FAIL m0_beat_err got=%b exp=0", beat_err);
        end
    endtask

    task automatic test_round_robin();
        ar_t got, exp;
        apply_reset();
        m_araddr  = {32'h0000_2000, 32'h0000_1000};
        m_arlen   = {8'd2, 8'd1};
        m_arvalid = 2'b11;
        exp_ar_q.push_back({1'b0, 32'h0000_1000, 8'd1});
        exp_ar_q.push_back({1'b1, 32'h0000_2000, 8'd2});
        serve(0, 2, 1'b0, 1'b0, -1, 32'h1);
        serve(0, 3, 1'b0, 1'b0, -1, 32'h2);
        n_checks++;
        if (ar_wait !== 1) begin
            n_fail++; $display("FAIL rr_idle_gap got=%0d exp=1", ar_wait);
        end
        // Third tie goes back to m0.
        m_araddr  = {32'h0000_4000, 32'h0000_3000};
        m_arlen   = {8'd0, 8'd0};
        m_arvalid = 2'b11;
        exp_ar_q.push_back({1'b0, 32'h0000_3000, 8'd0});
        exp_ar_q.push_back({1'b1, 32'h0000_4000, 8'd0});
        serve(1, 1, 1'b0, 1'b0, -1, 32'h3);
        serve(1, 1, 1'b0, 1'b0, -1, 32'h4);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            exp = exp_ar_q.pop_front();
            if (obs_ar_q.size() == 0) got = 'x; else got = obs_ar_q.pop_front();
            if (got !== exp) begin
                n_fail++; $display("FAIL rr_order_%0d got=%h exp=%h", i, got, exp);
            end
        end
        n_checks++;
        if (tmo !== 0) begin
            n_fail++; $display("FAIL rr_timeout got=%0d exp=0", tmo);
        end
        obs_r_q.delete();
    endtask

    task automatic test_contention();
        ar_t         got, exp;
        logic [63:0] ev, ov;
        m_araddr  = {32'h0000_9000, 32'h0000_5000};
        m_arlen   = {8'd1, 8'd5};
        m_arvalid = 2'b01;
        exp_ar_q.push_back({1'b0, 32'h0000_5000, 8'd5});
        exp_ar_q.push_back({1'b1, 32'h0000_9000, 8'd1});
        for (int b = 0; b < 6; b++) exp_r_q.push_back({32'h0000_00A0, 32'(b)});
        serve(0, 6, 1'b1, 1'b1, -1, 32'h0000_00A0);
        n_checks++;
        if (rr_mis !== 0) begin
            n_fail++; $display("FAIL cont_rready_mirror got=%0d exp=0", rr_mis);
        end
        n_checks++;
        if (other_ar !== 0) begin
            n_fail++; $display("FAIL cont_m1_arready got=%0d exp=0", other_ar);
        end
        n_checks++;
        if ({cnt_rv0, other_rv} !== {32'd6, 32'd0}) begin
            n_fail++; $display("FAIL cont_beats got=%0d/%0d exp=6/0", cnt_rv0, other_rv);
        end
        for (int b = 0; b < 2; b++) exp_r_q.push_back({32'h0000_00B0, 32'(b)});
        serve(0, 2, 1'b0, 1'b0, -1, 32'h0000_00B0);
        n_checks++;
        if ({cnt_rv1, cnt_rv0, rlast_beat} !== {32'd2, 32'd0, 32'd2}) begin
            n_fail++; $display("FAIL cont_m1_burst got=%0d/%0d/%0d exp=2/0/2", cnt_rv1, cnt_rv0, rlast_beat);
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            exp = exp_ar_q.pop_front();
            if (obs_ar_q.size() == 0) got = 'x; else got = obs_ar_q.pop_front();
            if (got !== exp) begin
                n_fail++; $display("FAIL cont_ar_%0d got=%h exp=%h", i, got, exp);
            end
        end
        while (exp_r_q.size() > 0) begin
            ev = exp_r_q.pop_front();
            if (obs_r_q.size() == 0) ov = 'x; else ov = obs_r_q.pop_front();
            n_checks++;
            if (ov !== ev) begin
                n_fail++; $display("FAIL cont_rdata got=%h exp=%h", ov, ev);
            end
        end
    endtask

    task automatic test_beat_err();
        m_araddr[31:0] = 32'h0000_6000;
        m_arlen[7:0]   = 8'd7;
        m_arvalid      = 2'b01;
        serve(0, 4, 1'b0, 1'b0, -1, 32'h6);
        n_checks++;
        if (beat_err !== 1'b1) begin
            n_fail++; $display("FAIL err_set got=%b exp=1", beat_err);
        end
        n_checks++;
        if (rlast_beat !== 4 || dut.r_state !== IDLE) begin
            n_fail++; $display("FAIL err_early_idle got=%0d/%0d exp=4/0", rlast_beat, dut.r_state);
        end
        m_araddr[63:32] = 32'h0000_7000;
        m_arlen[15:8]   = 8'd1;
        m_arvalid       = 2'b10;
        serve(0, 2, 1'b0, 1'b0, -1, 32'h7);
        n_checks++;
        if (beat_err !== 1'b1 || cnt_rv1 !== 2) begin
            n_fail++; $display("FAIL err_sticky got=%b/%0d exp=1/2", beat_err, cnt_rv1);
        end
        obs_ar_q.delete();
        obs_r_q.delete();
    endtask

    task automatic test_reset_mid_burst();
        ar_t got, exp;
        m_araddr[31:0] = 32'h0000_8000;
        m_arlen[7:0]   = 8'd7;
        m_arvalid      = 2'b01;
        serve(0, 8, 1'b0, 1'b0, 2, 32'h8);
        n_checks++;
        if (rst_snap !== 10'b00_0000_0010) begin
            n_fail++; $display("FAIL rst_mid_outputs got=%b exp=0000000010", rst_snap);
        end
        n_checks++;
        if (dut.r_state !== IDLE) begin
            n_fail++; $display("FAIL rst_mid_state got=%0d exp=0", dut.r_state);
        end
        obs_ar_q.delete();
        obs_r_q.delete();
        step();
        rst = 1'b1;
        step();
        m_araddr[63:32] = 32'h0000_A000;
        m_arlen[15:8]   = 8'd3;
        m_arvalid       = 2'b10;
        exp_ar_q.push_back({1'b1, 32'h0000_A000, 8'd3});
        serve(0, 4, 1'b0, 1'b0, -1, 32'hA);
        n_checks++;
        exp = exp_ar_q.pop_front();
        if (obs_ar_q.size() == 0) got = 'x; else got = obs_ar_q.pop_front();
        if (got !== exp) begin
            n_fail++; $display("FAIL rst_m1_ar got=%h exp=%h", got, exp);
        end
        n_checks++;
        if ({cnt_rv1, rlast_beat} !== {32'd4, 32'd4} || beat_err !== 1'b0) begin
            n_fail++; $display("FAIL rst_m1_burst got=%0d/%0d/%b exp=4/4/0", cnt_rv1, rlast_beat, beat_err);
        end
        n_checks++;
        if (tmo !== 0) begin
            n_fail++; $display("FAIL final_timeout got=%0d exp=0", tmo);
        end
        obs_r_q.delete();
    endtask

    initial begin
        tmo = 0;
        test_reset();
        test_m0_single();
        test_round_robin();
        test_contention();
        test_beat_err();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
